// File: rtl/mini_src_pkg.sv
// Shared opcodes, sequencer states and bus-source bit indices for the control sequencer.
// MUL_DIV_EN: when defined, mul/div decode to their own class; otherwise they behave as nop.
package mini_src_pkg;

  localparam int IR_W  = 32;
  localparam int NREGS = 16;
  localparam int SRC_W = 24;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Bus source bit positions; R0..R15 occupy bits 0..15 directly.
  typedef enum logic [4:0] {
    SRC_HI     = 5'd16,
    SRC_LO     = 5'd17,
    SRC_ZHI    = 5'd18,
    SRC_ZLO    = 5'd19,
    SRC_PC     = 5'd20,
    SRC_MDR    = 5'd21,
    SRC_INPORT = 5'd22,
    SRC_C      = 5'd23
  } src_idx_t;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_ALU, C_IMM, C_LD, C_ST, C_MULDIV, C_HALT
  } instr_class_t;

  function automatic instr_class_t classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return C_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:      return C_IMM;
      OP_LD:                         return C_LD;
      OP_ST:                         return C_ST;
      OP_HALT:                       return C_HALT;
`ifdef MUL_DIV_EN
      OP_MUL, OP_DIV:                return C_MULDIV;
`else
      OP_MUL, OP_DIV:                return C_NOP;
`endif
      OP_NOP:                        return C_NOP;
      default:                       return C_NOP;
    endcase
  endfunction

  // Immediate forms reuse the ALU operation of their register form.
  function automatic logic [4:0] aluOpFor(input logic [4:0] op);
    case (op)
      OP_ADDI: return OP_ADD;
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return op;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Signal bundle between the control sequencer (slave) and whoever feeds it the
// instruction and consumes its strobes (master).
interface control_sequencer_if;
  import mini_src_pkg::*;

  logic             run;
  logic             stop;
  logic [IR_W-1:0]  ir;
  logic [SRC_W-1:0] src_sel;
  logic [NREGS-1:0] r_in;
  logic             pc_in, inc_pc, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
  logic             mdr_rd, mem_rd, mem_wr;
  logic [4:0]       alu_op;
  logic             running, halted;

  modport master (
    output run, stop, ir,
    input  src_sel, r_in, pc_in, inc_pc, ir_in, mar_in, mdr_in, y_in, z_in,
           hi_in, lo_in, mdr_rd, mem_rd, mem_wr, alu_op, running, halted
  );

  modport slave (
    input  run, stop, ir,
    output src_sel, r_in, pc_in, inc_pc, ir_in, mar_in, mdr_in, y_in, z_in,
           hi_in, lo_in, mdr_rd, mem_rd, mem_wr, alu_op, running, halted
  );

endinterface

// File: rtl/reg_select_decode.sv
// Turns a 4-bit IR register field into a one-hot general-register select.
module reg_select_decode
  import mini_src_pkg::*;
(
  input  logic [3:0]       i_field,
  output logic [NREGS-1:0] o_onehot
);

  assign o_onehot = NREGS'(1) << i_field;

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: steps each instruction through T-states and drives bus strobes.
// MUL_DIV_EN: when defined, adds the mul/div sequence (lo_in/hi_in); otherwise they stay 0.
module control_sequencer
  import mini_src_pkg::*;
(
  input logic                clock,
  input logic                reset,
  control_sequencer_if.slave bus
);

  state_t           r_state;
  state_t           w_nextState;
  state_t           w_endState;
  instr_class_t     w_cls;
  logic [4:0]       w_op;
  logic [NREGS-1:0] w_raHot, w_rbHot, w_rcHot;
  logic             w_unusedIrBits;

  assign w_op           = bus.ir[31:27];
  assign w_cls          = classify(w_op);
  assign w_unusedIrBits = ^bus.ir[14:0];

  reg_select_decode uRa (.i_field(bus.ir[26:23]), .o_onehot(w_raHot));
  reg_select_decode uRb (.i_field(bus.ir[22:19]), .o_onehot(w_rbHot));
  reg_select_decode uRc (.i_field(bus.ir[18:15]), .o_onehot(w_rcHot));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // stop only matters on the last step of an instruction; halt ignores it.
  always_comb begin
    w_endState  = bus.stop ? S_HALT : S_T0;
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE, S_HALT: if (bus.run) w_nextState = S_T0;
      S_T0: w_nextState = S_T1;
      S_T1: w_nextState = S_T2;
      S_T2: w_nextState = S_T3;
      S_T3: begin
        if (w_cls == C_NOP)       w_nextState = w_endState;
        else if (w_cls == C_HALT) w_nextState = S_HALT;
        else                      w_nextState = S_T4;
      end
      S_T4: w_nextState = S_T5;
      S_T5: begin
        if (w_cls == C_LD || w_cls == C_ST || w_cls == C_MULDIV) w_nextState = S_T6;
        else                                                     w_nextState = w_endState;
      end
      S_T6: begin
        if (w_cls == C_LD || w_cls == C_ST) w_nextState = S_T7;
        else                                w_nextState = w_endState;
      end
      S_T7:    w_nextState = w_endState;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    bus.src_sel = '0;
    bus.r_in    = '0;
    bus.pc_in   = 1'b0;
    bus.inc_pc  = 1'b0;
    bus.ir_in   = 1'b0;
    bus.mar_in  = 1'b0;
    bus.mdr_in  = 1'b0;
    bus.y_in    = 1'b0;
    bus.z_in    = 1'b0;
    bus.hi_in   = 1'b0;
    bus.lo_in   = 1'b0;
    bus.mdr_rd  = 1'b0;
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.alu_op  = '0;
    bus.running = (r_state != S_IDLE) && (r_state != S_HALT);
    bus.halted  = (r_state == S_HALT);
    unique case (r_state)
      S_T0: begin
        bus.src_sel[SRC_PC] = 1'b1;
        bus.mar_in = 1'b1;
        bus.inc_pc = 1'b1;
        bus.z_in   = 1'b1;
        bus.alu_op = OP_ADD;
      end
      S_T1: begin
        bus.src_sel[SRC_ZLO] = 1'b1;
        bus.pc_in  = 1'b1;
        bus.mem_rd = 1'b1;
        bus.mdr_rd = 1'b1;
        bus.mdr_in = 1'b1;
      end
      S_T2: begin
        bus.src_sel[SRC_MDR] = 1'b1;
        bus.ir_in = 1'b1;
      end
      S_T3: begin
        case (w_cls)
          C_ALU, C_IMM, C_LD, C_ST: begin
            bus.src_sel[NREGS-1:0] = w_rbHot;
            bus.y_in = 1'b1;
          end
`ifdef MUL_DIV_EN
          C_MULDIV: begin
            bus.src_sel[NREGS-1:0] = w_raHot;
            bus.y_in = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T4: begin
        case (w_cls)
          C_ALU: begin
            bus.src_sel[NREGS-1:0] = w_rcHot;
            bus.z_in   = 1'b1;
            bus.alu_op = aluOpFor(w_op);
          end
          C_IMM: begin
            bus.src_sel[SRC_C] = 1'b1;
            bus.z_in   = 1'b1;
            bus.alu_op = aluOpFor(w_op);
          end
          C_LD, C_ST: begin
            bus.src_sel[SRC_C] = 1'b1;
            bus.z_in   = 1'b1;
            bus.alu_op = OP_ADD;
          end
`ifdef MUL_DIV_EN
          C_MULDIV: begin
            bus.src_sel[NREGS-1:0] = w_rbHot;
            bus.z_in   = 1'b1;
            bus.alu_op = w_op;
          end
`endif
          default: ;
        endcase
      end
      S_T5: begin
        case (w_cls)
          C_ALU, C_IMM: begin
            bus.src_sel[SRC_ZLO] = 1'b1;
            bus.r_in = w_raHot;
          end
          C_LD, C_ST: begin
            bus.src_sel[SRC_ZLO] = 1'b1;
            bus.mar_in = 1'b1;
          end
`ifdef MUL_DIV_EN
          C_MULDIV: begin
            bus.src_sel[SRC_ZLO] = 1'b1;
            bus.lo_in = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T6: begin
        case (w_cls)
          C_LD: begin
            bus.mem_rd = 1'b1;
            bus.mdr_rd = 1'b1;
            bus.mdr_in = 1'b1;
          end
          C_ST: begin
            bus.src_sel[NREGS-1:0] = w_raHot;
            bus.mdr_in = 1'b1;
          end
`ifdef MUL_DIV_EN
          C_MULDIV: begin
            bus.src_sel[SRC_ZHI] = 1'b1;
            bus.hi_in = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T7: begin
        case (w_cls)
          C_LD: begin
            bus.src_sel[SRC_MDR] = 1'b1;
            bus.r_in = w_raHot;
          end
          C_ST:    bus.mem_wr = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer; build with +define+MUL_DIV_EN to
// expect the mul/div sequence instead of mul decoding as nop.
module tb_control_sequencer;
  import mini_src_pkg::*;

  localparam logic [31:0] IR_ADD  = 32'h1989_0000;
  localparam logic [31:0] IR_LD   = 32'h0128_0010;
  localparam logic [31:0] IR_ST   = 32'h1208_0020;
  localparam logic [31:0] IR_ANDI = 32'h6890_0005;
  localparam logic [31:0] IR_SUB  = 32'h22B3_8000;
  localparam logic [31:0] IR_MUL  = 32'h7918_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;
  localparam logic [31:0] IR_UNK  = 32'hF800_0000;

  localparam logic [11:0] F_PCIN  = 12'b1000_0000_0000;
  localparam logic [11:0] F_INCPC = 12'b0100_0000_0000;
  localparam logic [11:0] F_IRIN  = 12'b0010_0000_0000;
  localparam logic [11:0] F_MARIN = 12'b0001_0000_0000;
  localparam logic [11:0] F_MDRIN = 12'b0000_1000_0000;
  localparam logic [11:0] F_YIN   = 12'b0000_0100_0000;
  localparam logic [11:0] F_ZIN   = 12'b0000_0010_0000;
  localparam logic [11:0] F_HIIN  = 12'b0000_0001_0000;
  localparam logic [11:0] F_LOIN  = 12'b0000_0000_1000;
  localparam logic [11:0] F_MDRRD = 12'b0000_0000_0100;
  localparam logic [11:0] F_MEMRD = 12'b0000_0000_0010;
  localparam logic [11:0] F_MEMWR = 12'b0000_0000_0001;

  logic clock;
  logic reset;
  int   testsRun;
  int   testsFailed;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
  end

  // Every output packed into one vector so a single compare covers the whole strobe set.
  function automatic logic [58:0] observed();
    return {bus.src_sel, bus.r_in, bus.pc_in, bus.inc_pc, bus.ir_in, bus.mar_in,
            bus.mdr_in, bus.y_in, bus.z_in, bus.hi_in, bus.lo_in, bus.mdr_rd,
            bus.mem_rd, bus.mem_wr, bus.alu_op, bus.running, bus.halted};
  endfunction

  function automatic logic [58:0] mkExp(input int srcBit, input int rBit, input logic [11:0] flags,
                                        input logic [4:0] op, input logic run, input logic hlt);
    logic [23:0] s;
    logic [15:0] r;
    s = '0;
    r = '0;
    if (srcBit >= 0) s[srcBit[4:0]] = 1'b1;
    if (rBit >= 0)   r[rBit[3:0]]   = 1'b1;
    return {s, r, flags, op, run, hlt};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input int srcBit, input int rBit, input logic [11:0] flags,
                            input logic [4:0] op, input logic run, input logic hlt);
    checkOutput(tag, 64'(observed()), 64'(mkExp(srcBit, rBit, flags, op, run, hlt)));
  endtask

  task automatic applyStimulus(input logic run, input logic stop, input logic [31:0] ir);
    bus.run  = run;
    bus.stop = stop;
    bus.ir   = ir;
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  // Checks T0..T2 starting from a sampled T0 and leaves the bench sampled in T3.
  task automatic checkFetch(input string name);
    checkState({name, " T0"}, 20, -1, F_MARIN | F_INCPC | F_ZIN, 5'b00011, 1'b1, 1'b0);
    stepCycle();
    checkState({name, " T1"}, 19, -1, F_PCIN | F_MEMRD | F_MDRRD | F_MDRIN, 5'b0, 1'b1, 1'b0);
    stepCycle();
    checkState({name, " T2"}, 21, -1, F_IRIN, 5'b0, 1'b1, 1'b0);
    stepCycle();
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      checkOutput("onehot src_sel", 64'($onehot0(bus.src_sel)), 64'd1);
      checkOutput("onehot r_in", 64'($onehot0(bus.r_in)), 64'd1);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    #2 checkState("reset", -1, -1, 12'h0, 5'b0, 1'b0, 1'b0);
    #6 reset = 1'b0;
    stepCycle();
    checkState("idle hold", -1, -1, 12'h0, 5'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, IR_ADD);
    stepCycle();
    applyStimulus(1'b0, 1'b0, IR_ADD);
    checkFetch("add");
    checkState("add T3", 1, -1, F_YIN, 5'b0, 1'b1, 1'b0);
    stepCycle();
    checkState("add T4", 2, -1, F_ZIN, 5'b00011, 1'b1, 1'b0);
    stepCycle();
    checkState("add T5", 19, 3, 12'h0, 5'b0, 1'b1, 1'b0);
    stepCycle();

    applyStimulus(1'b0, 1'b0, IR_LD);
    checkFetch("ld");
    checkState("ld T3", 5, -1, F_YIN, 5'b0, 1'b1, 1'b0);
    stepCycle();
    checkState("ld T4", 23, -1, F_ZIN, 5'b00011, 1'b1, 1'b0);
    stepCycle();
    checkState("ld T5", 19, -1, F_MARIN, 5'b0, 1'b1, 1'b0);
    stepCycle();
    checkState("ld T6", -1, -1, F_MEMRD | F_MDRRD | F_MDRIN, 5'b0, 1'b1, 1'b0);
    stepCycle();
    checkState("ld T7", 21, 2, 12'h0, 5'b0, 1'b1, 1'b0);
    stepCycle();

    applyStimulus(1'b0, 1'b0, IR_ST);
    checkFetch("st");
    checkState("st T3", 1, -1, F_YIN, 5'b0, 1'b1, 1'b0);
    stepCycle();
    checkState("st T4", 23, -1, F_ZIN, 5'b00011, 1'b1, 1'b0);
    stepCycle();
    checkState("st T5", 19, -1, F_MARIN, 5'b0, 1'b1, 1'b0);
    stepCycle();
    checkState("st T6", 4, -1, F_MDRIN, 5'b0, 1'b1, 1'b0);
    stepCycle();
    checkState("st T7", -1, -1, F_MEMWR, 5'b0, 1'b1, 1'b0);
    stepCycle();

    applyStimulus(1'b0, 1'b0, IR_ANDI);
    checkFetch("andi");
    checkState("andi T3", 2, -1, F_YIN, 5'b0, 1'b1, 1'b0);
    stepCycle();
    checkState("andi T4", 23, -1, F_ZIN, 5'b00101, 1'b1, 1'b0);
    stepCycle();
    checkState("andi T5", 19, 1, 12'h0, 5'b0, 1'b1, 1'b0);
    stepCycle();

    applyStimulus(1'b0, 1'b0, IR_SUB);
    checkFetch("sub");
    checkState("sub T3", 6, -1, F_YIN, 5'b0, 1'b1, 1'b0);
    stepCycle();
    checkState("sub T4", 7, -1, F_ZIN, 5'b00100, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, IR_SUB);
    stepCycle();
    checkState("sub T5", 19, 5, 12'h0, 5'b0, 1'b1, 1'b0);
    stepCycle();
    checkState("sub halted", -1, -1, 12'h0, 5'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, IR_SUB);
    stepCycle();
    checkState("halt hold", -1, -1, 12'h0, 5'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 1'b0, IR_MUL);
    stepCycle();
    applyStimulus(1'b0, 1'b0, IR_MUL);
    checkFetch("mul");
`ifdef MUL_DIV_EN
    checkState("mul T3", 2, -1, F_YIN, 5'b0, 1'b1, 1'b0);
    stepCycle();
    checkState("mul T4", 3, -1, F_ZIN, 5'b01111, 1'b1, 1'b0);
    stepCycle();
    checkState("mul T5", 19, -1, F_LOIN, 5'b0, 1'b1, 1'b0);
    stepCycle();
    checkState("mul T6", 18, -1, F_HIIN, 5'b0, 1'b1, 1'b0);
    stepCycle();
`else
    checkState("mul as nop T3", -1, -1, 12'h0, 5'b0, 1'b1, 1'b0);
    stepCycle();
`endif

    applyStimulus(1'b0, 1'b0, IR_HALT);
    checkFetch("halt");
    checkState("halt T3", -1, -1, 12'h0, 5'b0, 1'b1, 1'b0);
    stepCycle();
    checkState("halt instr", -1, -1, 12'h0, 5'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 1'b0, IR_ADD);
    stepCycle();
    applyStimulus(1'b0, 1'b0, IR_ADD);
    checkFetch("abort");
    checkState("abort T3", 1, -1, F_YIN, 5'b0, 1'b1, 1'b0);
    stepCycle();
    checkState("abort T4", 2, -1, F_ZIN, 5'b00011, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 checkState("abort async", -1, -1, 12'h0, 5'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    stepCycle();
    checkState("abort idle", -1, -1, 12'h0, 5'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, IR_UNK);
    stepCycle();
    checkFetch("run+stop");
    checkState("unknown T3", -1, -1, 12'h0, 5'b0, 1'b1, 1'b0);
    stepCycle();
    checkState("unknown stop", -1, -1, 12'h0, 5'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, IR_UNK);
    stepCycle();
    checkState("restart T0", 20, -1, F_MARIN | F_INCPC | F_ZIN, 5'b00011, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
